// File: rtl/hydration_alert_fsm.sv
// Dehydration/activity alert controller: per-sensor debounce, ranked state
// selection with minimum dwell before de-escalation, buzzer mute and a
// saturating SEVERE-entry counter. All outputs are registered.
module hydration_alert_fsm #(
  parameter int unsigned N_SENSORS    = 6,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned LIGHT_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_inputs,
  input  logic                 ack,
  output logic [5:0]           actuator_outputs,
  output logic [1:0]           state_code,
  output logic [7:0]           alarm_count
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned DW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PW = $clog2(N_SENSORS + 1);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_LIGHT    = 2'b01;
  localparam logic [1:0] ST_SEVERE   = 2'b10;
  localparam logic [1:0] ST_ACTIVITY = 2'b11;

  localparam logic [5:0] ACT_IDLE     = 6'b000000;
  localparam logic [5:0] ACT_LIGHT    = 6'b101100;
  localparam logic [5:0] ACT_ACTIVITY = 6'b101110;
  localparam logic [5:0] ACT_SEVERE   = 6'b111111;

  logic [N_SENSORS-1:0] f_q, f_d;
  logic [CW-1:0]        cnt_q [N_SENSORS];
  logic [CW-1:0]        cnt_d [N_SENSORS];
  logic [1:0]           state_q, state_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic                 mute_q, mute_d;
  logic [7:0]           alarm_q, alarm_d;
  logic [5:0]           act_q, act_d;
  logic [PW-1:0]        pop;
  logic [1:0]           target;

  // Severity rank; the state encoding itself is not ordered.
  function automatic logic [1:0] rank_of(input logic [1:0] st);
    logic [1:0] r;
    case (st)
      ST_LIGHT:    r = 2'd1;
      ST_ACTIVITY: r = 2'd2;
      ST_SEVERE:   r = 2'd3;
      default:     r = 2'd0;
    endcase
    return r;
  endfunction

  // Actuator pattern for a state; bit0 is the buzzer.
  function automatic logic [5:0] pattern_of(input logic [1:0] st, input logic mute);
    logic [5:0] p;
    case (st)
      ST_LIGHT:    p = ACT_LIGHT;
      ST_ACTIVITY: p = ACT_ACTIVITY;
      ST_SEVERE:   p = mute ? (ACT_SEVERE & 6'b111110) : ACT_SEVERE;
      default:     p = ACT_IDLE;
    endcase
    return p;
  endfunction

  // Next-state: debounce, target selection, transitions, sleep and counter.
  always_comb begin
    f_d     = f_q;
    state_d = state_q;
    dwell_d = dwell_q;
    mute_d  = mute_q;
    alarm_d = alarm_q;
    pop     = '0;
    target  = ST_IDLE;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      cnt_d[i] = cnt_q[i];
    end

    for (int i = 0; i < int'(N_SENSORS); i++) begin
      pop = pop + PW'(f_q[i]);
    end

    if (f_q[4] && f_q[0]) begin
      target = ST_SEVERE;
    end else if (f_q[5]) begin
      target = ST_ACTIVITY;
    end else if (pop >= PW'(LIGHT_THRESH)) begin
      target = ST_LIGHT;
    end

    for (int i = 0; i < int'(N_SENSORS); i++) begin
      if (sensor_inputs[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
        f_d[i]   = sensor_inputs[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    if (rank_of(target) > rank_of(state_q)) begin
      state_d = target;
      dwell_d = '0;
    end else if ((rank_of(target) < rank_of(state_q)) && (dwell_q == DW'(HOLD_CYCLES))) begin
      state_d = target;
      dwell_d = '0;
    end else if (dwell_q != DW'(HOLD_CYCLES)) begin
      dwell_d = dwell_q + DW'(1);
    end

    // Mute only survives while SEVERE is held; any exit or entry clears it.
    if ((state_q == ST_SEVERE) && (state_d == ST_SEVERE)) begin
      mute_d = mute_q | ack;
    end else begin
      mute_d = 1'b0;
    end

    if (!enable) begin
      f_d     = '0;
      state_d = ST_IDLE;
      dwell_d = '0;
      mute_d  = 1'b0;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        cnt_d[i] = '0;
      end
    end

    if ((state_d == ST_SEVERE) && (state_q != ST_SEVERE) && (alarm_q != 8'hFF)) begin
      alarm_d = alarm_q + 8'd1;
    end

    act_d = pattern_of(state_d, mute_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      state_q <= ST_IDLE;
      dwell_q <= '0;
      mute_q  <= 1'b0;
      alarm_q <= '0;
      act_q   <= ACT_IDLE;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      f_q     <= f_d;
      state_q <= state_d;
      dwell_q <= dwell_d;
      mute_q  <= mute_d;
      alarm_q <= alarm_d;
      act_q   <= act_d;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign actuator_outputs = act_q;
  assign state_code       = state_q;
  assign alarm_count      = alarm_q;

endmodule

// File: tb/tb_hydration_alert_fsm.sv
// Self-checking bench for hydration_alert_fsm: directed scenarios plus random
// segments, every cycle compared against a rank-based behavioural model.
module tb_hydration_alert_fsm;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int THR  = 2;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [5:0] sensor_inputs;
  logic       ack;
  logic [5:0] actuator_outputs;
  logic [1:0] state_code;
  logic [7:0] alarm_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: severity rank 0..3 and plain integer bookkeeping.
  int       m_rank;
  int       m_dwell;
  int       m_alarm;
  bit       m_mute;
  bit [5:0] m_f;
  int       m_run [6];

  hydration_alert_fsm #(
    .N_SENSORS(6), .DEBOUNCE(DEB), .HOLD_CYCLES(HOLD), .LIGHT_THRESH(THR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .sensor_inputs    (sensor_inputs),
    .ack              (ack),
    .actuator_outputs (actuator_outputs),
    .state_code       (state_code),
    .alarm_count      (alarm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rank = 0; m_dwell = 0; m_alarm = 0; m_mute = 0; m_f = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
  endtask

  function automatic logic [1:0] exp_code();
    logic [1:0] c;
    case (m_rank)
      1: c = 2'b01;
      2: c = 2'b11;
      3: c = 2'b10;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] exp_act();
    logic [5:0] a;
    case (m_rank)
      1: a = 6'b101100;
      2: a = 6'b101110;
      3: a = m_mute ? 6'b111110 : 6'b111111;
      default: a = 6'b000000;
    endcase
    return a;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [5:0] s, input logic a, input logic en);
    int tr;
    if (!en) begin
      m_f = '0; m_dwell = 0; m_mute = 0; m_rank = 0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
    end else begin
      if (m_f[4] && m_f[0])              tr = 3;
      else if (m_f[5])                   tr = 2;
      else if ($countones(m_f) >= THR)   tr = 1;
      else                               tr = 0;
      if (tr > m_rank) begin
        if (tr == 3 && m_alarm < 255) m_alarm++;
        m_rank = tr; m_dwell = 0; m_mute = 0;
      end else if (tr < m_rank && m_dwell == HOLD) begin
        m_rank = tr; m_dwell = 0; m_mute = 0;
      end else begin
        if (m_rank == 3 && a) m_mute = 1;
        if (m_dwell < HOLD) m_dwell++;
      end
      for (int i = 0; i < 6; i++) begin
        if (s[i] == m_f[i])          m_run[i] = 0;
        else if (m_run[i] == DEB - 1) begin m_f[i] = s[i]; m_run[i] = 0; end
        else                         m_run[i]++;
      end
    end
  endtask

  task automatic check_all();
    check_eq("state_code", 32'(state_code), 32'(exp_code()));
    check_eq("actuator", 32'(actuator_outputs), 32'(exp_act()));
    check_eq("alarm_count", 32'(alarm_count), 32'(m_alarm));
  endtask

  // Drive one cycle (1 ns after an edge), clock it, then compare.
  task automatic cyc(input logic [5:0] s, input logic a, input logic en);
    sensor_inputs = s; ack = a; enable = en;
    model_step(s, a, en);
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [5:0] rs;
  int         seg;
  int         alarm_before;

  initial begin
    rst_n = 1'b0; enable = 1'b1; sensor_inputs = '0; ack = 1'b0;
    model_reset();
    #12;
    check_eq("reset_state", 32'(state_code), 32'h0);
    check_eq("reset_act", 32'(actuator_outputs), 32'h0);
    check_eq("reset_alarm", 32'(alarm_count), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle with no sensors
    repeat (10) cyc(6'b000000, 1'b0, 1'b1);
    check_eq("idle_state", 32'(state_code), 32'h0);

    // Short pulse is filtered out
    repeat (3) cyc(6'b000011, 1'b0, 1'b1);
    repeat (6) cyc(6'b000000, 1'b0, 1'b1);
    check_eq("glitch_act", 32'(actuator_outputs), 32'h0);

    // LIGHT after exactly DEBOUNCE+1 edges, then ACTIVITY escalation
    repeat (4) cyc(6'b000011, 1'b0, 1'b1);
    check_eq("light_not_yet", 32'(state_code), 32'h0);
    cyc(6'b000011, 1'b0, 1'b1);
    check_eq("light_state", 32'(state_code), 32'h1);
    check_eq("light_act", 32'(actuator_outputs), 32'(6'b101100));
    repeat (5) cyc(6'b100000, 1'b0, 1'b1);
    check_eq("activity_state", 32'(state_code), 32'h3);
    check_eq("activity_act", 32'(actuator_outputs), 32'(6'b101110));

    // SEVERE entry, ack mute, exit and re-entry
    repeat (5) cyc(6'b010001, 1'b0, 1'b1);
    check_eq("severe_state", 32'(state_code), 32'h2);
    check_eq("severe_act", 32'(actuator_outputs), 32'(6'b111111));
    check_eq("severe_alarm1", 32'(alarm_count), 32'h1);
    cyc(6'b010001, 1'b1, 1'b1);
    check_eq("muted_act", 32'(actuator_outputs), 32'(6'b111110));
    repeat (12) cyc(6'b000000, 1'b0, 1'b1);
    check_eq("exit_idle", 32'(state_code), 32'h0);
    repeat (5) cyc(6'b010001, 1'b0, 1'b1);
    check_eq("reentry_act", 32'(actuator_outputs), 32'(6'b111111));
    check_eq("reentry_alarm2", 32'(alarm_count), 32'h2);

    // Dwell hold, then direct drop to IDLE
    repeat (6) cyc(6'b010001, 1'b0, 1'b1);
    repeat (4) cyc(6'b000000, 1'b0, 1'b1);
    check_eq("hold_still_severe", 32'(state_code), 32'h2);
    cyc(6'b000000, 1'b0, 1'b1);
    check_eq("hold_drop_idle", 32'(state_code), 32'h0);
    check_eq("hold_drop_act", 32'(actuator_outputs), 32'h0);

    // Sleep from LIGHT keeps alarm_count
    repeat (5) cyc(6'b000011, 1'b0, 1'b1);
    cyc(6'b000011, 1'b0, 1'b0);
    check_eq("sleep_idle", 32'(state_code), 32'h0);
    check_eq("sleep_alarm", 32'(alarm_count), 32'h2);

    // Async reset mid-SEVERE, between clock edges
    repeat (5) cyc(6'b010001, 1'b0, 1'b1);
    check_eq("pre_reset_severe", 32'(state_code), 32'h2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_act", 32'(actuator_outputs), 32'h0);
    check_eq("async_rst_alarm", 32'(alarm_count), 32'h0);
    check_eq("async_rst_state", 32'(state_code), 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Random segments of held sensor patterns
    for (int k = 0; k < 100; k++) begin
      rs  = 6'($urandom);
      seg = $urandom_range(1, 14);
      for (int j = 0; j < seg; j++) begin
        cyc(rs, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) != 0));
      end
    end

    // Counter saturation via repeated sleep/re-entry
    for (int k = 0; k < 260; k++) begin
      cyc(6'b010001, 1'b0, 1'b0);
      repeat (6) cyc(6'b010001, 1'b0, 1'b1);
    end
    check_eq("alarm_saturated", 32'(alarm_count), 32'd255);
    alarm_before = 32'(alarm_count);
    cyc(6'b010001, 1'b0, 1'b0);
    check_eq("alarm_held_sleep", 32'(alarm_count), 32'(alarm_before));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
